// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Multicycle multiply/divide unit with architectural HI/LO registers, placed
// in EX directly after the ALU control decoder. MULT/MULTU use a radix-2
// shift-add loop and DIV/DIVU a radix-2 restoring divider. Each takes WIDTH
// steps in CALC plus one FIX cycle for sign correction and the HI/LO
// write-back. oBusy is high for the whole operation so the pipeline can stall.
//
// Configuration macro:
//   MULDIV_FAST_MULT_EN  - when defined, MULT/MULTU use a single-cycle
//                          multiplier and go straight from IDLE to FIX.
//                          DIV/DIVU always use the iterative path.
//
// Ports:
//   iCLK         in   1      core clock, rising edge
//   iRST         in   1      synchronous active-high reset
//   iStart       in   1      operation request, qualifies iALUControl
//   iALUControl  in   5      ALU control code (OP* mult/div/HI/LO class)
//   iA           in   WIDTH  rs: dividend, multiplicand, or MTHI/MTLO data
//   iB           in   WIDTH  rt: divisor or multiplier
//   oBusy        out  1      high while an operation is in flight
//   oDone        out  1      one-cycle pulse after MULT/DIV updates HI/LO
//   oHI          out  WIDTH  HI register (MFHI reads it directly)
//   oLO          out  WIDTH  LO register (MFLO reads it directly)
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iStart,
    input  logic [4:0]       iALUControl,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oHI,
    output logic [WIDTH-1:0] oLO
);

    // Shared ALU control codes for the mult/div/HI/LO class.
    localparam logic [4:0] OPMULT  = 5'b10000;
    localparam logic [4:0] OPMULTU = 5'b10001;
    localparam logic [4:0] OPDIV   = 5'b10010;
    localparam logic [4:0] OPDIVU  = 5'b10011;
    localparam logic [4:0] OPMTHI  = 5'b10100;
    localparam logic [4:0] OPMTLO  = 5'b10101;
    localparam logic [4:0] OPMFHI  = 5'b10110;
    localparam logic [4:0] OPMFLO  = 5'b10111;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   count;
    // Shared working register.
    //   multiply: [2W-1:W] partial product, [W-1:0] multiplier shifting out
    //   divide:   [2W-1:W] partial remainder, [W-1:0] dividend in / quotient out
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;       // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_lo;    // negate product (mult) or quotient (div)
    logic               neg_hi;    // negate remainder (signed div)
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    // ---------------- operand decode ----------------
    logic             is_mul_op;
    logic             is_div_op;
    logic             is_signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign is_mul_op    = (iALUControl == OPMULT) || (iALUControl == OPMULTU);
    assign is_div_op    = (iALUControl == OPDIV)  || (iALUControl == OPDIVU);
    assign is_signed_op = (iALUControl == OPMULT) || (iALUControl == OPDIV);
    assign a_neg        = is_signed_op & iA[WIDTH-1];
    assign b_neg        = is_signed_op & iB[WIDTH-1];
    assign a_mag        = a_neg ? (~iA + 1'b1) : iA;
    assign b_mag        = b_neg ? (~iB + 1'b1) : iB;

`ifdef MULDIV_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

    // ---------------- one iteration step ----------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] step_acc;

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                     {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};

    // Restoring divide: shift the next dividend bit into the remainder and
    // try to subtract the divisor. The extra guard bit keeps the borrow
    // visible because the shifted remainder can reach 2*divisor-1.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opb};
    assign div_fits  = ~div_diff[WIDTH+1];

    always_comb begin
        if (is_div) begin
            if (div_fits) begin
                step_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // ---------------- sign fix-up ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod_fix = neg_lo ? (~acc + 1'b1) : acc;
    assign quo_fix  = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    assign rem_fix  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    assign fix_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

    // ---------------- FSM ----------------
    always_ff @(posedge iCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (iStart && is_div_op) begin
                    state_next = CALC;
                end else if (iStart && is_mul_op) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_next = FIX;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (count == LAST_STEP) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath and architectural registers ----------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            count  <= '0;
            acc    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        case (iALUControl)
                            OPMTHI: hi_q <= iA;
                            OPMTLO: lo_q <= iA;
                            OPMFHI, OPMFLO: begin
                                // Read path is combinational from oHI/oLO.
                            end
                            OPMULT, OPMULTU: begin
                                is_div <= 1'b0;
                                neg_lo <= a_neg ^ b_neg;
                                neg_hi <= 1'b0;
                                count  <= '0;
                                opb    <= a_mag;
`ifdef MULDIV_FAST_MULT_EN
                                acc    <= fast_prod;
`else
                                acc    <= {{WIDTH{1'b0}}, b_mag};
`endif
                            end
                            OPDIV, OPDIVU: begin
                                is_div <= 1'b1;
                                // A zero divisor yields an all-ones quotient
                                // that must not be sign-corrected; the
                                // remainder then equals the raw dividend.
                                neg_lo <= (a_neg ^ b_neg) & (iB != '0);
                                neg_hi <= a_neg;
                                count  <= '0;
                                opb    <= b_mag;
                                acc    <= {{WIDTH{1'b0}}, a_mag};
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                CALC: begin
                    acc   <= step_acc;
                    count <= count + 1'b1;
                end
                FIX: begin
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign oBusy = (state != IDLE);
    assign oDone = done_q;
    assign oHI   = hi_q;
    assign oLO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Scoreboard bench for muldiv_unit. The driver issues operations and pushes
// the reference HI/LO pair computed with plain 64-bit arithmetic; a monitor
// pops and compares every time oDone pulses. The driver also checks timing
// (busy length, done pulse), HI/LO hold during the operation, MTHI/MTLO,
// ignored requests while busy, and reset abort.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [4:0] OPMULT  = 5'b10000;
    localparam logic [4:0] OPMULTU = 5'b10001;
    localparam logic [4:0] OPDIV   = 5'b10010;
    localparam logic [4:0] OPDIVU  = 5'b10011;
    localparam logic [4:0] OPMTHI  = 5'b10100;
    localparam logic [4:0] OPMTLO  = 5'b10101;
    localparam logic [4:0] OPMFHI  = 5'b10110;
    localparam logic [4:0] OPMFLO  = 5'b10111;

`ifdef MULDIV_FAST_MULT_EN
    localparam bit FAST_MULT = 1'b1;
`else
    localparam bit FAST_MULT = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [4:0]   alu_ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iStart      (start),
        .iALUControl (alu_ctrl),
        .iA          (a),
        .iB          (b),
        .oBusy       (busy),
        .oDone       (done),
        .oHI         (hi),
        .oLO         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {HI, LO} from plain arithmetic.
    function automatic logic [63:0] ref_op(input logic [4:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint       sx;
        longint       sy;
        longint       q;
        longint       r;
        logic [63:0]  p;
        logic [63:0]  res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        res = '0;
        case (op)
            OPMULT: begin
                q   = sx * sy;
                res = q;
            end
            OPMULTU: begin
                p   = {32'b0, x} * {32'b0, y};
                res = p;
            end
            OPDIV: begin
                if (y == 0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    q   = sx / sy;
                    r   = sx % sy;
                    res = {r[31:0], q[31:0]};
                end
            end
            OPDIVU: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else        res = {x % y, x / y};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no pulse", hi, lo);
            end else begin
                e = sb.pop_front();
                check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
            end
        end
    end

    // Issue one MULT/DIV-class op and follow it to completion.
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input string name, input bit inject_mt);
        logic [63:0] r;
        int          busy_n;
        int          exp_busy;
        r        = ref_op(op, x, y);
        exp_busy = (FAST_MULT && (op == OPMULT || op == OPMULTU)) ? 1 : 33;
        @(negedge clk);
        start    = 1'b1;
        alu_ctrl = op;
        a        = x;
        b        = y;
        sb.push_back('{r[63:32], r[31:0], name});
        @(negedge clk);
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        busy_n = 0;
        while (busy && busy_n < 100) begin
            busy_n++;
            if (busy_n == 2) begin
                check({name, "_hold_hi"}, 64'(hi), 64'(model_hi));
                check({name, "_hold_lo"}, 64'(lo), 64'(model_lo));
            end
            if (inject_mt && busy_n == 3) begin
                start    = 1'b1;
                alu_ctrl = OPMTLO;
                a        = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        check({name, "_done"}, 64'(done), 64'd1);
        model_hi = r[63:32];
        model_lo = r[31:0];
    endtask

    // Single-cycle HI/LO access op in IDLE.
    task automatic run_mt(input logic [4:0] op, input logic [W-1:0] x);
        @(negedge clk);
        start    = 1'b1;
        alu_ctrl = op;
        a        = x;
        @(negedge clk);
        start = 1'b0;
        if (op == OPMTHI) model_hi = x;
        if (op == OPMTLO) model_lo = x;
        check("mt_busy", 64'(busy), 64'd0);
        check("mt_hi", 64'(hi), 64'(model_hi));
        check("mt_lo", 64'(lo), 64'(model_lo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]   op;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [4:0]   abort_op;

        rst      = 1'b1;
        start    = 1'b0;
        alu_ctrl = '0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        run_mt(OPMTHI, 32'hA5A5_A5A5);
        run_mt(OPMTLO, 32'h5A5A_5A5A);
        run_mt(OPMFHI, 32'h1111_1111);
        run_mt(OPMFLO, 32'h2222_2222);
        run_mt(5'b00011, 32'h3333_3333);

        run_op(OPMULT,  32'hFFFF_FFFF, 32'h0000_0002, "mult_neg1x2", 1'b0);
        run_op(OPMULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu_max_x2", 1'b0);
        run_op(OPDIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2", 1'b0);
        run_op(OPDIVU,  32'd100,       32'd7,         "divu_100_7", 1'b0);
        run_op(OPDIVU,  32'h1234_5678, 32'h0,         "divu_by_zero", 1'b0);
        run_op(OPDIV,   32'h8000_0005, 32'h0,         "div_neg_by_zero", 1'b0);
        run_op(OPDIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0);
        run_op(OPMULT,  32'h8000_0000, 32'h8000_0000, "mult_minxmin", 1'b0);
        run_op(OPDIV,   32'h0000_0007, 32'hFFFF_FFFE, "div_7_m2", 1'b0);
        run_op(OPDIV,   32'h1357_9BDF, 32'h0000_1234, "div_mtlo_ignored", 1'b1);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       op = OPMULT;
                1:       op = OPMULTU;
                2:       op = OPDIV;
                default: op = OPDIVU;
            endcase
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = 32'($urandom_range(1, 15));
                3: x = 32'($urandom_range(0, 255));
                default: begin end
            endcase
            run_op(op, x, y, "random", 1'b0);
        end

        // Reset mid-operation: result is discarded, no done pulse.
        abort_op = FAST_MULT ? OPDIVU : OPMULT;
        @(negedge clk);
        start    = 1'b1;
        alu_ctrl = abort_op;
        a        = 32'h0BAD_F00D;
        b        = 32'h0000_0777;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        rst      = 1'b0;
        model_hi = '0;
        model_lo = '0;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", 64'(busy), 64'd0);
        check("abort_idle_hi", 64'(hi), 64'd0);

        run_op(OPMULTU, 32'h0001_0000, 32'h0001_0000, "post_abort_multu", 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
